// File: rtl/regfile_mp.sv
// Multi-port register file with a busy scoreboard. Reads, rd_busy and bypass are combinational (0 cycles).
// Writes reach stored state after 1 cycle; busy_cnt is registered. There is no back-pressure: every write and issue is taken.
module regfile_mp #(
    parameter int DATA_W      = 32,
    parameter int NUM_REGS    = 32,
    parameter int NUM_RD      = 2,
    parameter int NUM_WR      = 1,
    parameter int BYPASS      = 1,
    parameter int ZERO_REG_EN = 1,
    localparam int IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*IDX_W-1:0]    rd_idx,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic [NUM_WR-1:0]          wr_en,
    input  logic [NUM_WR*IDX_W-1:0]    wr_idx,
    input  logic [NUM_WR*DATA_W-1:0]   wr_data,
    input  logic                       issue_en,
    input  logic [IDX_W-1:0]           issue_idx,
    input  logic                       flush,
    output logic [IDX_W:0]             busy_cnt
);

    localparam int CNT_W = IDX_W + 1;

    logic [DATA_W-1:0]   regs   [NUM_REGS];
    logic [DATA_W-1:0]   wr_val [NUM_REGS];
    logic [NUM_REGS-1:0] wr_hit;
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;
    logic [CNT_W-1:0]    cnt_nxt;

    // Index 0 is excluded when it is the hardwired zero register.
    function automatic logic reg_ok(input int k);
        return (ZERO_REG_EN == 0) || (k != 0);
    endfunction

    // Per-register write decode. Later ports overwrite earlier ones, so the highest port wins.
    always_comb begin
        wr_hit = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            wr_val[k] = '0;
            for (int p = 0; p < NUM_WR; p++) begin
                if (wr_en[p] && (wr_idx[p*IDX_W +: IDX_W] == IDX_W'(k)) && reg_ok(k)) begin
                    wr_hit[k] = 1'b1;
                    wr_val[k] = wr_data[p*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Read ports. An index that matches no valid register reads as 0 and not busy.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if ((rd_idx[i*IDX_W +: IDX_W] == IDX_W'(k)) && reg_ok(k)) begin
                    if ((BYPASS != 0) && wr_hit[k]) begin
                        rd_data[i*DATA_W +: DATA_W] = wr_val[k];
                        rd_busy[i]                  = 1'b0;
                    end else begin
                        rd_data[i*DATA_W +: DATA_W] = regs[k];
                        rd_busy[i]                  = busy[k];
                    end
                end
            end
        end
    end

    // Priority for each busy bit: flush, then issue (the new producer), then write retire.
    always_comb begin
        busy_nxt = busy;
        cnt_nxt  = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (flush) begin
                busy_nxt[k] = 1'b0;
            end else if (issue_en && (issue_idx == IDX_W'(k)) && reg_ok(k)) begin
                busy_nxt[k] = 1'b1;
            end else if (wr_hit[k]) begin
                busy_nxt[k] = 1'b0;
            end
            cnt_nxt = cnt_nxt + CNT_W'(busy_nxt[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs[k] <= '0;
            end
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (wr_hit[k]) begin
                    regs[k] <= wr_val[k];
                end
            end
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (with and without bypass) driven from the same inputs and checked against a behavioural model.
module tb_regfile_mp;

    localparam int DW  = 32;
    localparam int NR  = 24;
    localparam int NRD = 2;
    localparam int NWR = 2;
    localparam int IW  = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [NRD*IW-1:0]   rd_idx;
    logic [NRD*DW-1:0]   rd_data_b, rd_data_n;
    logic [NRD-1:0]      rd_busy_b, rd_busy_n;
    logic [NWR-1:0]      wr_en;
    logic [NWR*IW-1:0]   wr_idx;
    logic [NWR*DW-1:0]   wr_data;
    logic                issue_en;
    logic [IW-1:0]       issue_idx;
    logic                flush;
    logic [IW:0]         busy_cnt_b, busy_cnt_n;

    regfile_mp #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR), .BYPASS(1), .ZERO_REG_EN(1)) dut (
        .clk(clk), .rst(rst), .rd_idx(rd_idx), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .issue_en(issue_en),
        .issue_idx(issue_idx), .flush(flush), .busy_cnt(busy_cnt_b)
    );

    regfile_mp #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR), .BYPASS(0), .ZERO_REG_EN(1)) dut_nb (
        .clk(clk), .rst(rst), .rd_idx(rd_idx), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .issue_en(issue_en),
        .issue_idx(issue_idx), .flush(flush), .busy_cnt(busy_cnt_n)
    );

    // Architectural model, indexable by any 5-bit index.
    logic [DW-1:0] mem [32];
    bit            bsy [32];
    int            cnt_m;
    int            checks = 0;
    int            errors = 0;

    function automatic bit ok(input int idx);
        return (idx < NR) && (idx != 0);
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wr_en = '0; wr_idx = '0; wr_data = '0;
        issue_en = 1'b0; issue_idx = '0; flush = 1'b0;
    endtask

    task automatic set_rd(input int p, input int idx);
        rd_idx[p*IW +: IW] = IW'(idx);
    endtask

    task automatic set_wr(input int p, input int idx, input logic [DW-1:0] d);
        wr_en[p] = 1'b1;
        wr_idx[p*IW +: IW] = IW'(idx);
        wr_data[p*DW +: DW] = d;
    endtask

    task automatic set_issue(input int idx);
        issue_en = 1'b1;
        issue_idx = IW'(idx);
    endtask

    task automatic check_reads();
        int idx, widx;
        logic [DW-1:0] exp_d;
        logic exp_bsy, hit;
        for (int i = 0; i < NRD; i++) begin
            idx = int'(rd_idx[i*IW +: IW]);
            exp_d = '0; exp_bsy = 1'b0; hit = 1'b0;
            if (ok(idx)) begin
                exp_d = mem[idx];
                exp_bsy = bsy[idx];
            end
            chk($sformatf("rd_data_nobyp%0d", i), rd_data_n[i*DW +: DW], exp_d);
            chk($sformatf("rd_busy_nobyp%0d", i), {31'd0, rd_busy_n[i]}, {31'd0, exp_bsy});
            if (ok(idx)) begin
                for (int p = 0; p < NWR; p++) begin
                    widx = int'(wr_idx[p*IW +: IW]);
                    if (wr_en[p] && widx == idx) begin
                        exp_d = wr_data[p*DW +: DW];
                        hit = 1'b1;
                    end
                end
            end
            if (hit) exp_bsy = 1'b0;
            chk($sformatf("rd_data_byp%0d", i), rd_data_b[i*DW +: DW], exp_d);
            chk($sformatf("rd_busy_byp%0d", i), {31'd0, rd_busy_b[i]}, {31'd0, exp_bsy});
        end
    endtask

    task automatic model_edge();
        int widx;
        if (rst) begin
            for (int k = 0; k < 32; k++) begin
                mem[k] = '0;
                bsy[k] = 1'b0;
            end
        end else begin
            for (int p = 0; p < NWR; p++) begin
                widx = int'(wr_idx[p*IW +: IW]);
                if (wr_en[p] && ok(widx)) mem[widx] = wr_data[p*DW +: DW];
            end
            if (flush) begin
                for (int k = 0; k < 32; k++) bsy[k] = 1'b0;
            end else begin
                for (int p = 0; p < NWR; p++) begin
                    widx = int'(wr_idx[p*IW +: IW]);
                    if (wr_en[p] && ok(widx)) bsy[widx] = 1'b0;
                end
                if (issue_en && ok(int'(issue_idx))) bsy[int'(issue_idx)] = 1'b1;
            end
        end
        cnt_m = 0;
        for (int k = 0; k < 32; k++) cnt_m += int'(bsy[k]);
    endtask

    // Called just after a falling edge with the inputs for this cycle already set.
    task automatic cycle();
        #1;
        if (!rst) check_reads();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("busy_cnt_byp", {26'd0, busy_cnt_b}, DW'(cnt_m));
        chk("busy_cnt_nobyp", {26'd0, busy_cnt_n}, DW'(cnt_m));
    endtask

    initial begin
        for (int k = 0; k < 32; k++) begin
            mem[k] = '0;
            bsy[k] = 1'b0;
        end
        cnt_m = 0;
        rd_idx = '0;
        idle();
        rst = 1'b1;
        @(negedge clk);
        cycle();
        rst = 1'b0;
        set_rd(0, 5); set_rd(1, 1);
        cycle();
        chk("reset_cnt", {26'd0, busy_cnt_b}, 32'd0);

        // Reset discards stored data, busy state and a write in the reset cycle.
        set_wr(0, 5, 32'hDEADBEEF);
        cycle();
        idle(); set_issue(5);
        cycle();
        idle(); rst = 1'b1; set_wr(0, 12, 32'h1234);
        cycle();
        rst = 1'b0; idle(); set_rd(0, 5); set_rd(1, 12);
        #1;
        chk("rst_r5", rd_data_b[0 +: DW], 32'd0);
        chk("rst_r12", rd_data_b[DW +: DW], 32'd0);
        chk("rst_busy5", {31'd0, rd_busy_b[0]}, 32'd0);
        cycle();

        // Zero register.
        idle(); set_wr(0, 0, 32'hFFFFFFFF); set_issue(0); set_rd(0, 0);
        cycle();
        idle();
        cycle();
        chk("zero_data", rd_data_b[0 +: DW], 32'd0);
        chk("zero_cnt", {26'd0, busy_cnt_b}, 32'd0);

        // Two write ports hit r7: port 1 wins, in bypass and in stored state.
        set_wr(0, 7, 32'h11); set_wr(1, 7, 32'h22); set_rd(0, 7); set_rd(1, 7);
        #1;
        chk("byp_r7", rd_data_b[0 +: DW], 32'h22);
        chk("nobyp_r7_old", rd_data_n[0 +: DW], 32'h0);
        cycle();
        idle();
        #1;
        chk("stored_r7", rd_data_n[0 +: DW], 32'h22);
        cycle();

        // Scoreboard lifecycle on r3.
        set_issue(3); set_rd(0, 3);
        cycle();
        idle();
        #1;
        chk("r3_busy", {31'd0, rd_busy_b[0]}, 32'd1);
        chk("r3_cnt", {26'd0, busy_cnt_b}, 32'd1);
        cycle();
        set_wr(0, 3, 32'h55);
        #1;
        chk("r3_busy_byp", {31'd0, rd_busy_b[0]}, 32'd0);
        chk("r3_busy_nobyp", {31'd0, rd_busy_n[0]}, 32'd1);
        cycle();
        idle();
        cycle();

        // Issue and write on busy r9 at once: data updates, busy stays set.
        set_issue(9); set_rd(0, 9);
        cycle();
        idle(); set_issue(9); set_wr(1, 9, 32'h99);
        cycle();
        idle();
        #1;
        chk("r9_data", rd_data_n[0 +: DW], 32'h99);
        chk("r9_busy", {31'd0, rd_busy_b[0]}, 32'd1);
        cycle();

        // Flush beats a same-cycle issue.
        set_issue(1); cycle();
        set_issue(2); cycle();
        set_issue(4); cycle();
        idle(); flush = 1'b1; set_issue(6); set_rd(0, 6); set_rd(1, 4);
        cycle();
        idle();
        chk("flush_cnt", {26'd0, busy_cnt_b}, 32'd0);
        cycle();

        // Indices beyond NUM_REGS.
        set_wr(0, 30, 32'hAAAA); set_issue(30); set_rd(0, 30); set_rd(1, 31);
        cycle();
        idle();
        cycle();

        // Randomized traffic, biased so reads often hit same-cycle writes.
        for (int n = 0; n < 400; n++) begin
            idle();
            rst = ($urandom_range(63) == 0);
            flush = ($urandom_range(15) == 0);
            for (int p = 0; p < NWR; p++) begin
                if ($urandom_range(1) == 1) set_wr(p, $urandom_range(31), $urandom);
            end
            if ($urandom_range(1) == 1) set_issue($urandom_range(31));
            for (int i = 0; i < NRD; i++) begin
                if ($urandom_range(2) == 0) rd_idx[i*IW +: IW] = wr_idx[($urandom_range(1))*IW +: IW];
                else if ($urandom_range(1) == 0) set_rd(i, int'(issue_idx));
                else set_rd(i, $urandom_range(31));
            end
            cycle();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
